// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the RISC-V datapath and a req/ack data
// memory port with variable latency. One access at a time:
// IDLE -> BUS -> DONE -> IDLE.
// Optional feature macro: CONFIG_RISCV_LSU_MISALIGN_EXC_EN. When it is defined,
// misaligned h/w accesses skip the bus and finish with bus_err. When it is
// undefined, misaligned offsets are forced down and the access proceeds.
module riscv_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  // Access size encoding: 0 byte, 1 half, 2 word (undefined funct3 maps to word)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we, r_uns, r_bus_err;
  logic [1:0]        r_size, r_off;
  logic [31:0]       r_mem_addr, r_mem_wd, r_rdata;
  logic [3:0]        r_mem_be;

  logic [1:0]        w_size, w_off;
  logic              w_skip, w_accept, w_timeout;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;

  // Select the lane from the captured word and extend it to 32 bits
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_ext = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_ext = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  assign w_size    = (funct3[1:0] == 2'b11) ? SZ_W : funct3[1:0];
  assign w_accept  = (r_state == S_IDLE) && req;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Decode effective lane offset and whether the access bypasses the bus
  always_comb begin
    w_off  = addr[1:0];
    w_skip = 1'b0;
`ifdef CONFIG_RISCV_LSU_MISALIGN_EXC_EN
    w_skip = ((w_size == SZ_H) && addr[0]) || ((w_size == SZ_W) && (addr[1:0] != 2'b00));
`else
    case (w_size)
      SZ_B:    w_off = addr[1:0];
      SZ_H:    w_off = {addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
`endif
  end

  // Byte enables and lane-replicated store data for the access size
  always_comb begin
    w_be = 4'b1111;
    w_wd = wdata;
    case (w_size)
      SZ_B: begin
        w_be = 4'b0001 << w_off;
        w_wd = {4{wdata[7:0]}};
      end
      SZ_H: begin
        w_be = w_off[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = wdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: ack has priority over the timeout on the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req) w_state_nxt = w_skip ? S_DONE : S_BUS;
      S_BUS:   if (mem_ack || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the access on accept, count bus cycles, capture load data on ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= SZ_B;
      r_off      <= 2'b00;
      r_mem_addr <= '0;
      r_mem_be   <= '0;
      r_mem_wd   <= '0;
      r_rdata    <= '0;
      r_bus_err  <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_we       <= we;
      r_uns      <= funct3[2];
      r_size     <= w_size;
      r_off      <= w_off;
      r_mem_addr <= {addr[31:2], 2'b00};
      r_mem_be   <= w_be;
      r_mem_wd   <= w_wd;
      r_bus_err  <= w_skip;
    end else if (r_state == S_BUS) begin
      if (mem_ack) begin
        if (!r_we) r_rdata <= load_ext(mem_rd, r_off, r_size, r_uns);
      end else if (w_timeout) begin
        r_bus_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign mem_req  = (r_state == S_BUS);
  assign mem_we   = r_we;
  assign mem_addr = r_mem_addr;
  assign mem_be   = r_mem_be;
  assign mem_wd   = r_mem_wd;
  assign rdata    = r_rdata;
  assign bus_err  = r_bus_err;

endmodule
